counter_capture: RTL
====================

# counter_capture

Three-channel input-capture unit that measures period and high time of external or timer-generated pulse signals, e.g. the channel outputs of the 3-channel timer/counter. It is the read-side counterpart of the programmable timer. The CPU programs it and reads measured values through the same memory-mapped peripheral bus. Each channel synchronises its input to `clk`, timestamps edges with a free-running per-channel counter, and latches results with valid/overrun/saturation flags and an interrupt.

## Interface
- `CW`, 32: measurement counter and result width (8..32).
- `clk` input 1: single system clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `cap_in` input 3: raw capture inputs, one per channel, asynchronous to `clk`.
- `cap_we` input 1: bus write strobe, one cycle.
- `cap_re` input 1: bus read strobe, one cycle.
- `cap_addr` input 3: register select. 0-2 = PERIOD ch0-2; 4-6 = HIGH ch0-2; 3 = STATUS; 7 = CTRL.
- `cap_wdata` input 32: write data.
- `cap_rdata` output 32: registered read data, zero-extended from `CW`.
- `cap_irq` output 1: registered interrupt, level.

## Operation
- CTRL (R/W): [2:0] channel enable, [10:8] per-channel IRQ enable; other bits read 0.
- STATUS: [2:0] VALID (RO), [6:4] OVR (W1C), [10:8] SAT (W1C); other bits read 0. A write of 1 to a VALID bit is ignored.
- PERIOD/HIGH are read-only; writes to them are ignored.
- Input path: 2-flop synchroniser, then an edge register; rise/fall are single-cycle pulses.
- Per-channel FSM:
  - IDLE: entered from any state when the enable bit is 0. `cnt` and `hcnt` are 0; result registers are held.
  - ARM: entered from IDLE when enabled. Waits for the first rise, then goes to HIGH with `cnt`=1 and `hcnt`=1. No capture is made on this first rise.
  - HIGH: `cnt`++ and `hcnt`++ each cycle. On fall, go to LOW.
  - LOW: `cnt`++ each cycle; `hcnt` held. On rise: PERIOD<=`cnt`, HIGH<=`hcnt`, set VALID, then `cnt`=1, `hcnt`=1, go to HIGH.
- Saturation: `cnt` or `hcnt` at 2^CW-1 holds there and sets SAT. Results latched while saturated hold the all-ones value.
- A capture while VALID is already 1 sets OVR. The new values overwrite the old ones.
- Reading PERIOD of a channel clears that channel's VALID. Reading HIGH does not clear it.
- Simultaneous capture and clear of the same flag (VALID read, or OVR/SAT W1C): set wins.
- `cap_irq` = OR over channels of (VALID & IRQ enable), registered.
- `cap_we` and `cap_re` in the same cycle: both are performed. The read returns the pre-write value.
- Reset values: all registers 0, FSMs in IDLE, `cap_rdata`=0, `cap_irq`=0.
- Reset mid-measurement: everything returns to the reset state immediately, with no capture.

## Timing
- Edge detection latency: 3 `clk` cycles from an input transition to the rise/fall pulse.
- A steady input with period P cycles and high time H cycles captures PERIOD=P and HIGH=H exactly. Synchroniser delay cancels out.
- VALID and the result registers update on the cycle after the rise pulse.
- `cap_irq` asserts 1 cycle after VALID.
- `cap_rdata` is valid 1 cycle after `cap_re`. It holds its value until the next read.
- VALID clears 1 cycle after a PERIOD read. `cap_irq` deasserts 1 cycle after that.
- W1C writes and CTRL writes take effect on the next cycle.
- Clearing an enable bit forces IDLE on the next cycle. The first capture after re-enable requires two further rises.
- Minimum measurable high or low phase is 1 cycle. Inputs faster than 2 cycles per period are not supported (aliasing).

## Test plan
- Reset/defaults:
  - Stimulus: assert `rst` mid-count.
  - Required: all reads return 0 and `cap_irq`=0; after release, no capture until enable plus two rises.
- Basic capture:
  - Stimulus: enable ch0, drive a 100-cycle period with 30 cycles high.
  - Required: PERIOD0=100, HIGH0=30, VALID0=1.
  - Then read PERIOD0: `cap_rdata`=100 next cycle, VALID0=0 the cycle after.
- Interrupt and overrun:
  - Stimulus: IRQ enable on ch1, ch1 running a 50-cycle period, never read.
  - Required: `cap_irq`=1; OVR1=1 after the second capture, with PERIOD1=50.
  - Then W1C write of 0x20: OVR1=0.
- Saturation:
  - Stimulus: CW=8, ch2 input held high for 300 cycles after arming.
  - Required: `hcnt` holds at 255 and SAT2=1. The next capture gives HIGH2=255 and PERIOD2=255.
- Simultaneous events:
  - Stimulus: PERIOD0 read in the same cycle a new ch0 capture completes.
  - Required: read returns the old value and VALID0 remains 1.
- Disable mid-operation:
  - Stimulus: clear CTRL[0] while ch0 is in HIGH.
  - Required: the result registers keep their last values. After re-enable, the first rise gives no capture and the second rise captures correctly.

Source files
------------

// File: rtl/counter_capture.sv
// counter_capture: three-channel input-capture unit measuring period and high
// time of pulse inputs, with a small register file on the peripheral bus.
module counter_capture #(
   parameter int CW = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  cap_in,
   input  logic        cap_we,
   input  logic        cap_re,
   input  logic [2:0]  cap_addr,
   input  logic [31:0] cap_wdata,
   output logic [31:0] cap_rdata,
   output logic        cap_irq
);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_t;

   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   function automatic logic at_max(input logic [CW-1:0] v);
      return v == CNT_MAX;
   endfunction

   logic [2:0]    sync_p0, sync_p1, lvl_p2, rise_p2, fall_p2;
   state_t        state_q [3];
   state_t        state_d [3];
   logic [CW-1:0] cnt_q [3];
   logic [CW-1:0] cnt_d [3];
   logic [CW-1:0] hcnt_q [3];
   logic [CW-1:0] hcnt_d [3];
   logic [CW-1:0] per_q [3];
   logic [CW-1:0] hi_q [3];
   logic [2:0]    cap_evt, sat_evt;
   logic [2:0]    en_q, ien_q, valid_q, ovr_q, sat_q;
   logic [2:0]    rd_clr, ovr_w1c, sat_w1c;
   logic          ctrl_wr, stat_wr;
   logic [31:0]   rd_mux;
   logic          unused_wdata;

   assign unused_wdata = ^{cap_wdata[31:11], cap_wdata[7], cap_wdata[3]};

   // Two-flop synchroniser followed by the edge register producing rise/fall pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         lvl_p2  <= '0;
         rise_p2 <= '0;
         fall_p2 <= '0;
      end else begin
         sync_p0 <= cap_in;
         sync_p1 <= sync_p0;
         lvl_p2  <= sync_p1;
         rise_p2 <= sync_p1 & ~lvl_p2;
         fall_p2 <= ~sync_p1 & lvl_p2;
      end
   end

   // Per-channel measurement state and counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            state_q[i] <= S_IDLE;
            cnt_q[i]   <= '0;
            hcnt_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            hcnt_q[i]  <= hcnt_d[i];
         end
      end
   end

   // Next-state logic: the arming rise only starts counting; later rises capture.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         hcnt_d[i]  = hcnt_q[i];
         cap_evt[i] = 1'b0;
         sat_evt[i] = 1'b0;
         if (!en_q[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
            hcnt_d[i]  = '0;
         end else begin
            case (state_q[i])
               S_IDLE: state_d[i] = S_ARM;
               S_ARM: begin
                  if (rise_p2[i]) begin
                     state_d[i] = S_HIGH;
                     cnt_d[i]   = CNT_ONE;
                     hcnt_d[i]  = CNT_ONE;
                  end
               end
               S_HIGH: begin
                  cnt_d[i] = sat_inc(cnt_q[i]);
                  if (at_max(cnt_q[i])) sat_evt[i] = 1'b1;
                  if (fall_p2[i]) begin
                     state_d[i] = S_LOW;
                  end else begin
                     hcnt_d[i] = sat_inc(hcnt_q[i]);
                     if (at_max(hcnt_q[i])) sat_evt[i] = 1'b1;
                  end
               end
               default: begin
                  if (rise_p2[i]) begin
                     cap_evt[i] = 1'b1;
                     state_d[i] = S_HIGH;
                     cnt_d[i]   = CNT_ONE;
                     hcnt_d[i]  = CNT_ONE;
                  end else begin
                     cnt_d[i] = sat_inc(cnt_q[i]);
                     if (at_max(cnt_q[i])) sat_evt[i] = 1'b1;
                  end
               end
            endcase
         end
      end
   end

   // Bus decode: write strobes, read-side VALID clears and the read mux.
   always_comb begin
      ctrl_wr = cap_we && (cap_addr == 3'd7);
      stat_wr = cap_we && (cap_addr == 3'd3);
      ovr_w1c = stat_wr ? cap_wdata[6:4] : 3'b000;
      sat_w1c = stat_wr ? cap_wdata[10:8] : 3'b000;
      rd_mux  = '0;
      for (int i = 0; i < 3; i++) begin
         rd_clr[i] = cap_re && (cap_addr == 3'(i));
         if (cap_addr == 3'(i))     rd_mux[CW-1:0] = per_q[i];
         if (cap_addr == 3'(i + 4)) rd_mux[CW-1:0] = hi_q[i];
      end
      if (cap_addr == 3'd3) rd_mux = {21'd0, sat_q, 1'b0, ovr_q, 1'b0, valid_q};
      if (cap_addr == 3'd7) rd_mux = {21'd0, ien_q, 5'd0, en_q};
   end

   // Control, status flags (set beats clear) and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_q    <= '0;
         ien_q   <= '0;
         valid_q <= '0;
         ovr_q   <= '0;
         sat_q   <= '0;
         for (int i = 0; i < 3; i++) begin
            per_q[i] <= '0;
            hi_q[i]  <= '0;
         end
      end else begin
         if (ctrl_wr) begin
            en_q  <= cap_wdata[2:0];
            ien_q <= cap_wdata[10:8];
         end
         valid_q <= cap_evt | (valid_q & ~rd_clr);
         ovr_q   <= (cap_evt & valid_q) | (ovr_q & ~ovr_w1c);
         sat_q   <= sat_evt | (sat_q & ~sat_w1c);
         for (int i = 0; i < 3; i++) begin
            if (cap_evt[i]) begin
               per_q[i] <= cnt_q[i];
               hi_q[i]  <= hcnt_q[i];
            end
         end
      end
   end

   // Registered read data and interrupt.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_rdata <= '0;
         cap_irq   <= 1'b0;
      end else begin
         if (cap_re) cap_rdata <= rd_mux;
         cap_irq <= |(valid_q & ien_q);
      end
   end

endmodule
